// File: rtl/dcache_2way_top.sv
// -----------------------------------------------------------------------------
// dcache_2way_top
// Two-way set-associative, write-back, write-allocate data cache sitting between
// the CPU memory stage (p1 side) and a line-wide data memory. One LRU bit per set,
// tag/line storage held internally, and saturating hit/miss counters.
//
// Ports
//   clk_i, rst_i              clock (rising edge), asynchronous active-low reset
//   p1_addr_i                 CPU byte address (bits [1:0] ignored)
//   p1_data_i                 store data
//   p1_MemRead_i              load request
//   p1_MemWrite_i             store request (wins over a simultaneous load)
//   p1_data_o                 load data, valid while request high and stall low
//   p1_stall_o                request cannot complete this cycle
//   mem_data_i, mem_ack_i     refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o    write-back line, line-aligned memory address
//   mem_enable_o, mem_write_o memory request and its direction (registered)
//   hit_cnt_o, miss_cnt_o     saturating performance counters
// -----------------------------------------------------------------------------
module dcache_2way_top #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;

    // Address fields of the current request.
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [OFF_W+2:0]  bit_off;         // bit position of the selected word in a line
    logic              unused_addr_bits;

    assign tag              = p1_addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign idx              = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign word             = p1_addr_i[OFF_W-1:2];
    assign bit_off          = {word, 5'd0};
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // Storage: status bits are reset, tag/line arrays are not.
    logic [1:0][SETS-1:0] valid;
    logic [1:0][SETS-1:0] dirty;
    logic [SETS-1:0]      lru;          // holds the least-recently-used way
    logic [TAG_W-1:0]     tag_mem  [2][SETS];
    logic [LINE_W-1:0]    line_mem [2][SETS];

    state_t state, state_d;
    logic   victim, victim_d;
    logic   after_refill;               // first IDLE cycle after REFILL_DONE

    // Next values of the registered memory-side outputs.
    logic              en_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] wdata_d;
    logic              refill_we;

    // Lookup
    logic              req, hit0, hit1, hit, hit_way;
    logic              lookup_hit, store_hit;
    logic [LINE_W-1:0] hit_line;

    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign hit0       = valid[0][idx] && (tag_mem[0][idx] == tag);
    assign hit1       = valid[1][idx] && (tag_mem[1][idx] == tag);
    assign hit        = hit0 | hit1;
    assign hit_way    = ~hit0;          // way 0 wins should both ever match
    assign hit_line   = line_mem[hit_way][idx];
    assign p1_data_o  = hit ? hit_line[bit_off +: 32] : 32'd0;
    assign p1_stall_o = req & ((state != IDLE) | ~hit);
    assign lookup_hit = (state == IDLE) && req && hit;
    assign store_hit  = lookup_hit && p1_MemWrite_i;

    // Next-state and memory-request logic.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d   = state;
        victim_d  = victim;
        en_d      = mem_enable_o;
        we_d      = mem_write_o;
        addr_d    = mem_addr_o;
        wdata_d   = mem_data_o;
        refill_we = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_d  = MISS;
                    victim_d = !valid[0][idx] ? 1'b0 :
                               !valid[1][idx] ? 1'b1 : lru[idx];
                end
            end
            MISS: begin
                en_d = 1'b1;
                if (valid[victim][idx] && dirty[victim][idx]) begin
                    state_d = WRITEBACK;
                    we_d    = 1'b1;
                    addr_d  = {tag_mem[victim][idx], idx, {OFF_W{1'b0}}};
                    wdata_d = line_mem[victim][idx];
                end else begin
                    state_d = REFILL;
                    we_d    = 1'b0;
                    addr_d  = {tag, idx, {OFF_W{1'b0}}};
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = REFILL;
                    we_d    = 1'b0;
                    addr_d  = {tag, idx, {OFF_W{1'b0}}};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d   = REFILL_DONE;
                    en_d      = 1'b0;
                    refill_we = 1'b1;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            victim       <= 1'b0;
            after_refill <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            valid        <= '0;
            dirty        <= '0;
            lru          <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            state        <= state_d;
            victim       <= victim_d;
            after_refill <= (state == REFILL_DONE);
            mem_enable_o <= en_d;
            mem_write_o  <= we_d;
            mem_addr_o   <= addr_d;
            mem_data_o   <= wdata_d;
            if (refill_we) begin
                valid[victim][idx] <= 1'b1;
                dirty[victim][idx] <= 1'b0;
            end
            if (store_hit) dirty[hit_way][idx] <= 1'b1;
            if (lookup_hit) lru[idx] <= ~hit_way;
            // The access completing right after a refill was already counted as a miss.
            if (lookup_hit && !after_refill && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            if ((state == IDLE) && req && !hit && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + CNT_W'(1);
        end
    end

    // NOTE: tag and line arrays carry no reset; valid bits gate their use, and
    // leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            tag_mem[victim][idx]  <= tag;
            line_mem[victim][idx] <= mem_data_i;
        end else if (store_hit) begin
            line_mem[hit_way][idx][bit_off +: 32] <= p1_data_i;
        end
    end

endmodule
